// File: rtl/crypto_pkg.sv
// Shared types for the crypto command responder.
// FSM states, engine mode encoding and error-flag bit positions.
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } cr_state_t;

  typedef enum logic [1:0] {
    MODE_HASH = 2'b00,
    MODE_ENC  = 2'b01,
    MODE_DEC  = 2'b10
  } cr_mode_t;

  localparam int ERR_MULTI = 0;
  localparam int ERR_SPUR  = 1;
  localparam int ERR_TO    = 2;

  function automatic cr_mode_t pick_mode(
    input logic h,
    input logic e
  );
    if (h)
      return MODE_HASH;
    else if (e)
      return MODE_ENC;
    else
      return MODE_DEC;
  endfunction

endpackage

// File: rtl/crypto_wdog.sv
// Engine watchdog: cleared on launch, counts while enabled.
// Saturates instead of wrapping so a stuck WAIT cannot re-arm it.
module crypto_wdog #(
  parameter int TO_W   = 8,
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/crypto_cmd_responder.sv
// Responder for CPU hash/encrypt/decrypt requests.
// Launches the shared engine and stalls the CPU until result or timeout.
module crypto_cmd_responder
  import crypto_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              H_int,
  input  logic              E_int,
  input  logic              D_int,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              clr_err,
  output logic              stall,
  output logic              res_wr,
  output logic [DATA_W-1:0] res_data,
  output logic              eng_start,
  output logic [1:0]        eng_mode,
  output logic [DATA_W-1:0] eng_din,
  output logic [DATA_W-1:0] eng_key,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_dout,
  output logic [2:0]        err
);

  cr_state_t state, state_n;

  logic any_int;
  logic multi;
  logic busy;
  logic done_ok;
  logic expire;
  logic [2:0] err_set;

  assign any_int = H_int | E_int | D_int;
  assign multi   = (H_int & E_int)
                 | (H_int & D_int)
                 | (E_int & D_int);
  assign busy    = (state == ISSUE)
                 || (state == WAIT);
  assign done_ok = eng_done && busy;

  crypto_wdog #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (any_int) state_n = ISSUE;
      ISSUE: state_n = eng_done ? RESP : WAIT;
      WAIT:  if (eng_done || expire) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reset gates stall so the CPU is released while rst_n is low.
  always_comb begin
    stall     = 1'b0;
    eng_start = 1'b0;
    res_wr    = 1'b0;
    unique case (state)
      IDLE:  stall = rst_n & any_int;
      ISSUE: begin
        stall     = rst_n;
        eng_start = 1'b1;
      end
      WAIT:  stall = rst_n;
      RESP:  res_wr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_mode <= '0;
      eng_din  <= '0;
      eng_key  <= '0;
      res_data <= '0;
    end else begin
      if (state == IDLE && any_int) begin
        eng_mode <= pick_mode(H_int, E_int);
        eng_din  <= op_a;
        eng_key  <= op_b;
      end
      if (done_ok)
        res_data <= eng_dout;
      else if (expire)
        res_data <= '0;
    end
  end

  always_comb begin
    err_set            = '0;
    err_set[ERR_TO]    = expire && !eng_done;
    err_set[ERR_SPUR]  = eng_done && !busy;
    err_set[ERR_MULTI] = (state == IDLE) && multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= '0;
    else
      err <= (err & ~{3{clr_err}}) | err_set;
  end

endmodule

// File: tb/tb_crypto_cmd_responder.sv
// Randomized and directed bench for crypto_cmd_responder.
// Expected timing and flags come from a request-level model.
module tb_crypto_cmd_responder;

  localparam int DW     = 16;
  localparam int TO_CYC = 4;
  localparam int TO_W   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h, e, d, clr;
  logic [DW-1:0] a, b;
  logic          stall, res_wr, eng_start;
  logic [DW-1:0] res_data, eng_din, eng_key;
  logic [1:0]    eng_mode;
  logic          eng_done;
  logic [DW-1:0] eng_dout;
  logic [2:0]    err;

  crypto_cmd_responder #(
    .DATA_W (DW),
    .TO_CYC (TO_CYC),
    .TO_W   (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .H_int     (h),
    .E_int     (e),
    .D_int     (d),
    .op_a      (a),
    .op_b      (b),
    .clr_err   (clr),
    .stall     (stall),
    .res_wr    (res_wr),
    .res_data  (res_data),
    .eng_start (eng_start),
    .eng_mode  (eng_mode),
    .eng_din   (eng_din),
    .eng_key   (eng_key),
    .eng_done  (eng_done),
    .eng_dout  (eng_dout),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total    = 0;

  int            o_starts, o_start_c, o_resp_c;
  int            o_start_abs, o_resp_abs, o_stall;
  logic          o_stall_resp;
  logic [1:0]    o_mode;
  logic [DW-1:0] o_din, o_key, o_data;
  logic [2:0]    exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    h = 0; e = 0; d = 0; clr = 0;
    eng_done = 0; eng_dout = '0;
  endtask

  task automatic clear_err();
    clr = 1;
    tick();
    clr = 0;
    exp_err = '0;
  endtask

  // Model: engine answer k cycles after launch is accepted while k <= TO_CYC.
  function automatic int exp_resp(input int delay);
    if (delay >= 0 && delay <= TO_CYC)
      return 2 + delay;
    return 2 + TO_CYC;
  endfunction

  function automatic logic [1:0] exp_mode(input logic hh, ee);
    if (hh) return 2'b00;
    if (ee) return 2'b01;
    return 2'b10;
  endfunction

  task automatic do_req(
    input logic          hh, ee, dd,
    input logic [DW-1:0] aa, bb,
    input int            delay,
    input logic [DW-1:0] dout
  );
    o_starts = 0; o_start_c = -1; o_resp_c = -1;
    o_stall = 0; o_stall_resp = 1'bx;
    o_mode = 'x; o_din = 'x; o_key = 'x; o_data = 'x;
    h = hh; e = ee; d = dd; a = aa; b = bb;
    for (int c = 0; c < TO_CYC + 10; c++) begin
      eng_done = (delay >= 0) && (c == delay + 1);
      eng_dout = eng_done ? dout : DW'($urandom);
      #1;
      if (stall) o_stall++;
      if (eng_start) begin
        o_starts++;
        o_start_c = c;
        o_start_abs = cyc;
        o_mode = eng_mode;
        o_din = eng_din;
        o_key = eng_key;
      end
      if (c == 1) begin
        a = DW'($urandom);
        b = DW'($urandom);
      end
      if (res_wr) begin
        o_resp_c = c;
        o_resp_abs = cyc;
        o_data = res_data;
        o_stall_resp = stall;
        idle_inputs();
        tick();
        break;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    a = '0; b = '0;
    rst_n = 0;
    tick(); tick();
    total++;
    if ({stall, res_wr, eng_start} !== 3'b000) begin
      $display("FAIL reset_ctl got=%b want=000", {stall, res_wr, eng_start});
    end else pass_cnt++;
    total++;
    if ({err, eng_mode, eng_din, eng_key, res_data} !== '0) begin
      $display("FAIL reset_regs err=%b mode=%b din=%h key=%h res=%h want all 0",
               err, eng_mode, eng_din, eng_key, res_data);
    end else pass_cnt++;
    rst_n = 1;
    tick();
    exp_err = '0;
  endtask

  task automatic test_encrypt();
    clear_err();
    do_req(0, 1, 0, 16'h1234, 16'hBEEF, 3, 16'h5A5A);
    total++;
    if (o_starts !== 1 || o_start_c !== 1) begin
      $display("FAIL enc_start got n=%0d at=%0d want n=1 at=1", o_starts, o_start_c);
    end else pass_cnt++;
    total++;
    if ({o_mode, o_din, o_key} !== {2'b01, 16'h1234, 16'hBEEF}) begin
      $display("FAIL enc_latch got mode=%b din=%h key=%h want 01/1234/beef",
               o_mode, o_din, o_key);
    end else pass_cnt++;
    total++;
    if (o_stall !== 5 || o_resp_c !== 5 || o_data !== 16'h5A5A) begin
      $display("FAIL enc_resp got stall=%0d resp=%0d data=%h want 5/5/5a5a",
               o_stall, o_resp_c, o_data);
    end else pass_cnt++;
    total++;
    if (err !== 3'b000) begin
      $display("FAIL enc_err got=%b want=000", err);
    end else pass_cnt++;
  endtask

  task automatic test_multi();
    clear_err();
    do_req(1, 1, 0, DW'($urandom), DW'($urandom), 1, 16'hC0DE);
    total++;
    if (o_mode !== 2'b00 || err !== 3'b001) begin
      $display("FAIL multi got mode=%b err=%b want 00/001", o_mode, err);
    end else pass_cnt++;
    clr = 1;
    tick();
    clr = 0;
    total++;
    if (err !== 3'b000) begin
      $display("FAIL clr_err got=%b want=000", err);
    end else pass_cnt++;
    exp_err = '0;
  endtask

  task automatic test_timeout();
    clear_err();
    do_req(0, 0, 1, 16'h0F0F, 16'hF0F0, -1, '0);
    total++;
    if (o_resp_c !== 2 + TO_CYC || o_data !== '0) begin
      $display("FAIL timeout_resp got resp=%0d data=%h want %0d/0000",
               o_resp_c, o_data, 2 + TO_CYC);
    end else pass_cnt++;
    total++;
    if (o_stall_resp !== 1'b0 || o_mode !== 2'b10 || err !== 3'b100) begin
      $display("FAIL timeout_flags got stall=%b mode=%b err=%b want 0/10/100",
               o_stall_resp, o_mode, err);
    end else pass_cnt++;
  endtask

  task automatic test_spurious();
    clear_err();
    eng_done = 1;
    eng_dout = 16'hDEAD;
    #1;
    total++;
    if (res_wr !== 1'b0) begin
      $display("FAIL spur_wr got=%b want=0", res_wr);
    end else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total++;
    if (err !== 3'b010 || res_wr !== 1'b0) begin
      $display("FAIL spur_err got err=%b wr=%b want 010/0", err, res_wr);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_done_issue();
    logic [DW-1:0] v;
    clear_err();
    v = DW'($urandom);
    do_req(1, 0, 0, DW'($urandom), DW'($urandom), 0, v);
    total++;
    if (o_resp_c !== 2 || o_data !== v || err !== 3'b000) begin
      $display("FAIL done_issue got resp=%0d data=%h err=%b want 2/%h/000",
               o_resp_c, o_data, err, v);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r1;
    clear_err();
    do_req(1, 0, 0, 16'h1111, 16'h2222, 2, 16'h3333);
    r1 = o_resp_abs;
    total++;
    if (o_starts !== 1 || o_mode !== 2'b00 || o_data !== 16'h3333) begin
      $display("FAIL b2b_first got n=%0d mode=%b data=%h want 1/00/3333",
               o_starts, o_mode, o_data);
    end else pass_cnt++;
    do_req(0, 0, 1, 16'h4444, 16'h5555, 1, 16'h6666);
    total++;
    if (o_starts !== 1 || o_mode !== 2'b10 || o_start_abs - r1 !== 2) begin
      $display("FAIL b2b_second got n=%0d mode=%b gap=%0d want 1/10/2",
               o_starts, o_mode, o_start_abs - r1);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0]    ints;
    logic [DW-1:0] ra, rb, rv;
    int            dly;
    logic          to, mul;
    clear_err();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) clear_err();
      ints = 3'($urandom_range(1, 7));
      ra = DW'($urandom);
      rb = DW'($urandom);
      rv = DW'($urandom);
      dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO_CYC));
      to = !(dly >= 0 && dly <= TO_CYC);
      mul = (ints[2] + ints[1] + ints[0]) > 1;
      exp_err = exp_err | {to, 1'b0, mul};
      do_req(ints[2], ints[1], ints[0], ra, rb, dly, rv);
      total++;
      if (o_starts !== 1 || o_mode !== exp_mode(ints[2], ints[1])
          || o_din !== ra || o_key !== rb) begin
        $display("FAIL rand%0d_issue got n=%0d mode=%b din=%h key=%h want 1/%b/%h/%h",
                 i, o_starts, o_mode, o_din, o_key, exp_mode(ints[2], ints[1]), ra, rb);
      end else pass_cnt++;
      total++;
      if (o_resp_c !== exp_resp(dly) || o_data !== (to ? '0 : rv)
          || o_stall !== exp_resp(dly)) begin
        $display("FAIL rand%0d_resp got resp=%0d stall=%0d data=%h want %0d/%0d/%h",
                 i, o_resp_c, o_stall, o_data, exp_resp(dly), exp_resp(dly),
                 to ? '0 : rv);
      end else pass_cnt++;
      total++;
      if (err !== exp_err) begin
        $display("FAIL rand%0d_err got=%b want=%b", i, err, exp_err);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    idle_inputs();
    h = 1; e = 1; a = 16'hAAAA; b = 16'h5555;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    total++;
    if ({stall, res_wr, eng_start, err} !== 6'b0) begin
      $display("FAIL reset_mid got stall=%b wr=%b start=%b err=%b want 0/0/0/000",
               stall, res_wr, eng_start, err);
    end else pass_cnt++;
    idle_inputs();
    tick();
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (res_wr || eng_start || stall) bad = 1;
      tick();
    end
    total++;
    if (bad !== 1'b0) begin
      $display("FAIL reset_abort got activity=%b want=0", bad);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_multi();
    test_timeout();
    test_spurious();
    test_done_issue();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
